// File: rtl/demux_stream_feeder.sv
// Serialises tagged parallel words onto a 1-to-2 demux (a = data, e = enable, s = select).
// Optional: define DEMUX_FEED_PARITY_EN to append an even-parity bit after each word.
module demux_stream_feeder #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1,
  parameter int MSB_FIRST  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dest,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             a,
  output logic             e,
  output logic             s,
  output logic             busy,
  output logic             word_done
);

`ifdef DEMUX_FEED_PARITY_EN
  localparam int BITS = WIDTH + 1;
`else
  localparam int BITS = WIDTH;
`endif
  localparam int CW       = $clog2(BITS + 1);
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             a_q, a_d, e_q, e_d, s_q, s_d, wd_q, wd_d;
`ifdef DEMUX_FEED_PARITY_EN
  logic             par_q, par_d;
`endif

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_on(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  // cnt_q counts bits still to be presented after the one currently on a
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    a_d     = 1'b0;
    e_d     = 1'b0;
    s_d     = s_q;
    wd_d    = 1'b0;
`ifdef DEMUX_FEED_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
          a_d     = head_bit(in_data);
          e_d     = 1'b1;
          s_d     = in_dest;
          sreg_d  = shift_on(in_data);
          cnt_d   = CW'(BITS - 1);
`ifdef DEMUX_FEED_PARITY_EN
          par_d   = ^in_data;
`endif
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          e_d    = 1'b1;
          a_d    = head_bit(sreg_q);
          sreg_d = shift_on(sreg_q);
          cnt_d  = cnt_q - CW'(1);
`ifdef DEMUX_FEED_PARITY_EN
          if (cnt_q == CW'(1)) a_d = par_q;
`endif
        end else begin
          wd_d = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = GW'(GAP_LOAD);
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      a_q     <= 1'b0;
      e_q     <= 1'b0;
      s_q     <= 1'b0;
      wd_q    <= 1'b0;
`ifdef DEMUX_FEED_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      a_q     <= a_d;
      e_q     <= e_d;
      s_q     <= s_d;
      wd_q    <= wd_d;
`ifdef DEMUX_FEED_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign busy      = (state_q != IDLE);
  assign a         = a_q;
  assign e         = e_q;
  assign s         = s_q;
  assign word_done = wd_q;

endmodule

// File: tb/tb_demux_stream_feeder.sv
// Bench for demux_stream_feeder: dut0 uses defaults, dut1 uses GAP_CYCLES=0 / LSB-first.
module tb_demux_stream_feeder;
  localparam int W = 8;
`ifdef DEMUX_FEED_PARITY_EN
  localparam int BLEN = W + 1;
`else
  localparam int BLEN = W;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data, d2;
  logic       in_dest, dst2, in_valid, v2;
  logic       in_ready, a, e, s, busy, word_done;
  logic       rdy2, a2, e2, s2, busy2, wd2;

  always #5 clk = ~clk;

  demux_stream_feeder #(.WIDTH(8), .GAP_CYCLES(1), .MSB_FIRST(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_dest(in_dest), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .e(e), .s(s), .busy(busy), .word_done(word_done));

  demux_stream_feeder #(.WIDTH(8), .GAP_CYCLES(0), .MSB_FIRST(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(d2), .in_dest(dst2), .in_valid(v2),
    .in_ready(rdy2), .a(a2), .e(e2), .s(s2), .busy(busy2), .word_done(wd2));

  int total = 0;
  int passed = 0;

  logic [63:0] c_e, c_a, c_s, c_wd, c_rdy, c_busy;
  logic [63:0] x_e, x_a, x_s, x_wd, x_rdy;

  // Records n cycles of one DUT's outputs, one sample per falling edge
  task automatic capture(input bit which, input int n, input int drop);
    c_e = '0; c_a = '0; c_s = '0; c_wd = '0; c_rdy = '0; c_busy = '0;
    for (int i = 0; i < n; i++) begin
      c_e[i]    = which ? e2    : e;
      c_a[i]    = which ? a2    : a;
      c_s[i]    = which ? s2    : s;
      c_wd[i]   = which ? wd2   : word_done;
      c_rdy[i]  = which ? rdy2  : in_ready;
      c_busy[i] = which ? busy2 : busy;
      if (i == drop) begin in_valid = 1'b0; v2 = 1'b0; end
      @(negedge clk);
    end
  endtask

  // Offers a word and returns at the falling edge of the first cycle after acceptance
  task automatic send(input bit which, input logic [7:0] d, input bit dst, input bit hold,
                      output bit ok);
    int n = 0;
    if (which) begin d2 = d; dst2 = dst; v2 = 1'b1; end
    else begin in_data = d; in_dest = dst; in_valid = 1'b1; end
    while (((which ? rdy2 : in_ready) !== 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 100);
    @(negedge clk);
    if (!hold) begin in_valid = 1'b0; v2 = 1'b0; end
  endtask

  task automatic model_clear();
    x_e = '0; x_a = '0; x_s = '0; x_wd = '0; x_rdy = '1;
  endtask

  // Expected trace of one word whose first bit appears at index base
  task automatic model_add(input bit lsb, input int gap, input int base, input logic [7:0] d,
                           input bit dst);
    for (int i = 0; i < BLEN; i++) begin
      x_e[base+i] = 1'b1;
      x_s[base+i] = dst;
      x_a[base+i] = (i < W) ? (lsb ? d[i] : d[W-1-i]) : ^d;
    end
    x_wd[base+BLEN] = 1'b1;
    for (int i = 0; i < BLEN + gap; i++) x_rdy[base+i] = 1'b0;
  endtask

  function automatic logic [63:0] mask(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; v2 = 1'b0;
    in_data = '0; in_dest = 1'b0; d2 = '0; dst2 = 1'b0;
    #7;
    total++;
    if ({a, e, s, busy, word_done, in_ready} !== 6'b0)
      $display("FAIL reset_dut0 got=%b want=000000", {a, e, s, busy, word_done, in_ready});
    else passed++;
    total++;
    if ({a2, e2, s2, busy2, wd2, rdy2} !== 6'b0)
      $display("FAIL reset_dut1 got=%b want=000000", {a2, e2, s2, busy2, wd2, rdy2});
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, rdy2} !== 2'b11) $display("FAIL ready_after_reset got=%b want=11", {in_ready, rdy2});
    else passed++;
    capture(0, 4, -1);
    total++;
    if ((c_e | c_busy | c_wd) !== 64'd0)
      $display("FAIL idle_quiet e=%h busy=%h wd=%h want 0", c_e, c_busy, c_wd);
    else passed++;
    @(posedge clk); #2 rst_n = 1'b0; #1;
    total++;
    if (in_ready !== 1'b0) $display("FAIL ready_in_async_reset got=%b want=0", in_ready);
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    bit ok;
    int n = BLEN + 3;
    send(0, 8'hA5, 1'b1, 1'b0, ok);
    total++;
    if (!ok) $display("FAIL single_accept timeout got=0 want=1"); else passed++;
    capture(0, n, -1);
    model_clear(); model_add(0, 1, 0, 8'hA5, 1'b1);
    total++;
    if (c_a[7:0] !== 8'hA5) $display("FAIL single_bits got=%b want=10100101(first bit at right)", c_a[7:0]);
    else passed++;
    total++;
    if ((c_e & mask(n)) !== (x_e & mask(n))) $display("FAIL single_e got=%h want=%h", c_e & mask(n), x_e & mask(n));
    else passed++;
    total++;
    if ((c_s & x_e) !== (x_s & x_e)) $display("FAIL single_s got=%h want=%h", c_s & x_e, x_s & x_e);
    else passed++;
    total++;
    if ((c_wd & mask(n)) !== (x_wd & mask(n))) $display("FAIL single_wd got=%h want=%h", c_wd & mask(n), x_wd & mask(n));
    else passed++;
    total++;
    if ((c_rdy & mask(n)) !== (x_rdy & mask(n))) $display("FAIL single_ready got=%h want=%h", c_rdy & mask(n), x_rdy & mask(n));
    else passed++;
  endtask

  task automatic test_back_to_back(input bit which);
    bit ok;
    int gap = which ? 0 : 1;
    int b2 = BLEN + gap + 1;
    int n = b2 + BLEN + 2;
    int zeros = 0;
    logic [7:0] w0 = which ? 8'h01 : 8'h0F;
    logic [7:0] w1 = which ? 8'h80 : 8'hF0;
    send(which, w0, 1'b0, 1'b1, ok);
    total++;
    if (!ok) $display("FAIL b2b_accept%0d timeout got=0 want=1", which); else passed++;
    if (which) begin d2 = w1; dst2 = 1'b1; end else begin in_data = w1; in_dest = 1'b1; end
    capture(which, n, b2);
    model_clear();
    model_add(which, gap, 0, w0, 1'b0);
    model_add(which, gap, b2, w1, 1'b1);
    for (int i = BLEN; i < b2; i++) if (c_e[i] == 1'b0) zeros++;
    total++;
    if (zeros != gap + 1) $display("FAIL b2b_gap%0d got=%0d want=%0d", which, zeros, gap + 1);
    else passed++;
    total++;
    if ((c_a & mask(n)) !== (x_a & mask(n))) $display("FAIL b2b_a%0d got=%h want=%h", which, c_a & mask(n), x_a & mask(n));
    else passed++;
    total++;
    if ((c_e & mask(n)) !== (x_e & mask(n))) $display("FAIL b2b_e%0d got=%h want=%h", which, c_e & mask(n), x_e & mask(n));
    else passed++;
    total++;
    if ((c_s & x_e) !== (x_s & x_e)) $display("FAIL b2b_s%0d got=%h want=%h", which, c_s & x_e, x_s & x_e);
    else passed++;
    total++;
    if ((c_rdy & mask(n)) !== (x_rdy & mask(n))) $display("FAIL b2b_ready%0d got=%h want=%h", which, c_rdy & mask(n), x_rdy & mask(n));
    else passed++;
  endtask

  task automatic test_reset_mid_word();
    bit ok;
    int n = BLEN + 3;
    send(0, 8'hFF, 1'b0, 1'b0, ok);
    total++;
    if (!ok) $display("FAIL midrst_accept timeout got=0 want=1"); else passed++;
    @(negedge clk); @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0; #1;
    total++;
    if ({e, a, busy, word_done} !== 4'b0) $display("FAIL midrst_drop got=%b want=0000", {e, a, busy, word_done});
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    capture(0, 4, -1);
    total++;
    if ((c_wd | c_e) !== 64'd0) $display("FAIL midrst_no_done wd=%h e=%h want 0", c_wd, c_e);
    else passed++;
    send(0, 8'h3C, 1'b1, 1'b0, ok);
    capture(0, n, -1);
    model_clear(); model_add(0, 1, 0, 8'h3C, 1'b1);
    total++;
    if (!ok || (c_a & mask(n)) !== (x_a & mask(n)) || (c_e & mask(n)) !== (x_e & mask(n)))
      $display("FAIL midrst_next_word a=%h want=%h e=%h want=%h", c_a & mask(n), x_a & mask(n), c_e & mask(n), x_e & mask(n));
    else passed++;
  endtask

  task automatic test_parity();
    bit ok;
    logic [7:0] w [2];
    w[0] = 8'hA5; w[1] = 8'h07;
    for (int k = 0; k < 2; k++) begin
      send(0, w[k], 1'b0, 1'b0, ok);
      capture(0, BLEN + 3, -1);
      total++;
      if (!ok || c_e[BLEN:0] !== {1'b0, {BLEN{1'b1}}})
        $display("FAIL parity_len%0d got=%b want=%b", k, c_e[BLEN:0], {1'b0, {BLEN{1'b1}}});
      else passed++;
      total++;
      if (c_wd[BLEN:0] !== {1'b1, {BLEN{1'b0}}})
        $display("FAIL parity_done%0d got=%b want=%b", k, c_wd[BLEN:0], {1'b1, {BLEN{1'b0}}});
      else passed++;
`ifdef DEMUX_FEED_PARITY_EN
      total++;
      if (c_a[8] !== (k == 1)) $display("FAIL parity_bit%0d got=%b want=%b", k, c_a[8], (k == 1));
      else passed++;
`endif
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int t = 0; t < 40; t++) begin
      bit which = 1'($urandom_range(0, 1));
      int gap = which ? 0 : 1;
      int n = BLEN + gap + 2;
      logic [7:0] d = 8'($urandom);
      bit dst = 1'($urandom_range(0, 1));
      int idle = $urandom_range(0, 3);
      for (int i = 0; i < idle; i++) @(negedge clk);
      send(which, d, dst, 1'b0, ok);
      capture(which, n, -1);
      model_clear(); model_add(which, gap, 0, d, dst);
      total++;
      if (!ok || (c_a & mask(n)) !== (x_a & mask(n)) || (c_e & mask(n)) !== (x_e & mask(n)) ||
          (c_s & x_e) !== (x_s & x_e) || (c_wd & mask(n)) !== (x_wd & mask(n)) ||
          (c_rdy & mask(n)) !== (x_rdy & mask(n)))
        $display("FAIL random%0d dut%0d d=%h dst=%b a=%h/%h e=%h/%h wd=%h/%h rdy=%h/%h", t, which, d, dst,
                 c_a & mask(n), x_a & mask(n), c_e & mask(n), x_e & mask(n),
                 c_wd & mask(n), x_wd & mask(n), c_rdy & mask(n), x_rdy & mask(n));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back(0);
    test_back_to_back(1);
    test_reset_mid_word();
    test_parity();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
